// File: rtl/gf180mcu_osu_sc_clkdiv_pkg.sv
// Shared types and defaults for the programmable clock divider cell.
// Provides the handshake state encoding and the default counter width / reset ratio.
package gf180mcu_osu_sc_clkdiv_pkg;

  localparam int CLKDIV_CNT_W   = 8;
  localparam int CLKDIV_DIV_RST = 0;

  typedef enum logic [1:0] {
    ST_RUN  = 2'd0,
    ST_PEND = 2'd1,
    ST_ACK  = 2'd2
  } clkdiv_state_e;

endpackage

// File: rtl/gf180mcu_osu_sc_12t_clkdiv_cnt.sv
// Divider counter and CLKO toggle flop; tc is combinational, clko toggles on the edge after tc.
// Gating (en=0) parks the divider with clko low and cnt at zero; no backpressure.
module gf180mcu_osu_sc_12t_clkdiv_cnt #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [CNT_W-1:0] div_q,
  input  logic             load,
  input  logic             en,
  output logic             tc,
  output logic             clko
);

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             clko_q, clko_d;
  logic             hold;

  always_comb begin
    tc     = (cnt_q == div_q);
    // Only park once clko is already low, so a gated clock never shortens a high phase.
    hold   = ~en & ~clko_q & (tc | (cnt_q == '0));
    cnt_d  = tc ? '0 : cnt_q + CNT_ONE;
    clko_d = tc ? ~clko_q : clko_q;
    if (hold) begin
      cnt_d  = '0;
      clko_d = clko_q;
    end
    if (load) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      clko_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      clko_q <= clko_d;
    end
  end

  assign clko = clko_q;

endmodule

// File: rtl/gf180mcu_osu_sc_12t_clkdiv_prog.sv
// Glitch-free programmable divider: CLKO period 2*(div+1); new ratio applied at a CLKO fall via 4-phase req/ack.
// Optional EN gate input when GF180MCU_OSU_SC_CLKDIV_GATE_EN is defined; requests wait in BUSY until applied.
module gf180mcu_osu_sc_12t_clkdiv_prog
  import gf180mcu_osu_sc_clkdiv_pkg::*;
#(
  parameter int CNT_W   = CLKDIV_CNT_W,
  parameter int DIV_RST = CLKDIV_DIV_RST
) (
  input  logic             CLK,
  input  logic             RN,
`ifdef GF180MCU_OSU_SC_CLKDIV_GATE_EN
  input  logic             EN,
`endif
  input  logic             DIV_REQ,
  input  logic [CNT_W-1:0] DIV_VAL,
  output logic             DIV_ACK,
  output logic             BUSY,
  output logic             CLKO
);

  localparam logic [CNT_W-1:0] DIV_RST_V = CNT_W'(DIV_RST);

  clkdiv_state_e    state_q, state_d;
  logic [CNT_W-1:0] div_q, div_d;
  logic [CNT_W-1:0] div_nxt_q, div_nxt_d;
  logic             busy_q, busy_d;
  logic             ack_q, ack_d;
  logic             load;
  logic             apply;
  logic             tc;
  logic             clko;
  logic             en_int;

`ifdef GF180MCU_OSU_SC_CLKDIV_GATE_EN
  assign en_int = EN;
`else
  assign en_int = 1'b1;
`endif

  gf180mcu_osu_sc_12t_clkdiv_cnt #(
    .CNT_W (CNT_W)
  ) u_cnt (
    .clk   (CLK),
    .rst_n (RN),
    .div_q (div_q),
    .load  (load),
    .en    (en_int),
    .tc    (tc),
    .clko  (clko)
  );

  always_comb begin
    state_d   = state_q;
    div_d     = div_q;
    div_nxt_d = div_nxt_q;
    busy_d    = busy_q;
    ack_d     = ack_q;
    load      = 1'b0;
    // Swapping the ratio only at the high->low toggle keeps every phase at least one full old or new length.
    apply     = (state_q == ST_PEND) & tc & clko;
    case (state_q)
      ST_RUN: begin
        if (DIV_REQ) begin
          div_nxt_d = DIV_VAL;
          busy_d    = 1'b1;
          state_d   = ST_PEND;
        end
      end
      ST_PEND: begin
        if (apply) begin
          div_d   = div_nxt_q;
          load    = 1'b1;
          busy_d  = 1'b0;
          ack_d   = 1'b1;
          state_d = ST_ACK;
        end
      end
      ST_ACK: begin
        if (!DIV_REQ) begin
          ack_d   = 1'b0;
          state_d = ST_RUN;
        end
      end
      default: begin
        state_d = ST_RUN;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RN) begin
    if (!RN) begin
      state_q   <= ST_RUN;
      div_q     <= DIV_RST_V;
      div_nxt_q <= '0;
      busy_q    <= 1'b0;
      ack_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      div_q     <= div_d;
      div_nxt_q <= div_nxt_d;
      busy_q    <= busy_d;
      ack_q     <= ack_d;
    end
  end

  assign DIV_ACK = ack_q;
  assign BUSY    = busy_q;
  assign CLKO    = clko;

endmodule

// File: tb/tb_gf180mcu_osu_sc_12t_clkdiv_prog.sv
// Bench for the programmable clock divider: ratio table, corner sequences and random handshake traffic
// checked cycle by cycle against a phase-length reference model.
module tb_gf180mcu_osu_sc_12t_clkdiv_prog;

  localparam int CNT_W   = 8;
  localparam int DIV_RST = 0;

  logic             CLK;
  logic             RN;
  logic             DIV_REQ;
  logic [CNT_W-1:0] DIV_VAL;
  logic             DIV_ACK;
  logic             BUSY;
  logic             CLKO;
`ifdef GF180MCU_OSU_SC_CLKDIV_GATE_EN
  logic             EN;
`endif

  gf180mcu_osu_sc_12t_clkdiv_prog #(
    .CNT_W   (CNT_W),
    .DIV_RST (DIV_RST)
  ) dut (
    .CLK     (CLK),
    .RN      (RN),
`ifdef GF180MCU_OSU_SC_CLKDIV_GATE_EN
    .EN      (EN),
`endif
    .DIV_REQ (DIV_REQ),
    .DIV_VAL (DIV_VAL),
    .DIV_ACK (DIV_ACK),
    .BUSY    (BUSY),
    .CLKO    (CLKO)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: remaining cycles of the current CLKO phase, plus handshake flags.
  int m_div;
  int m_nxt;
  int m_left;
  bit m_clko;
  bit m_busy;
  bit m_ack;

  typedef struct {
    int val;
    int period;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_div  = DIV_RST;
    m_nxt  = 0;
    m_left = DIV_RST + 1;
    m_clko = 1'b0;
    m_busy = 1'b0;
    m_ack  = 1'b0;
  endtask

  task automatic model_edge(input bit req, input int val);
    bit ph_end;
    ph_end = (m_left == 1);
    if (m_busy) begin
      if (ph_end && m_clko) begin
        m_div  = m_nxt;
        m_busy = 1'b0;
        m_ack  = 1'b1;
      end
    end else if (m_ack) begin
      if (!req) m_ack = 1'b0;
    end else if (req) begin
      m_nxt  = val;
      m_busy = 1'b1;
    end
    if (ph_end) begin
      m_clko = !m_clko;
      m_left = m_div + 1;
    end else begin
      m_left = m_left - 1;
    end
  endtask

  task automatic step();
    bit req;
    int val;
    req = DIV_REQ;
    val = int'(DIV_VAL);
    @(posedge CLK);
    #1;
    model_edge(req, val);
    chk("model_clko", int'(CLKO), int'(m_clko));
    chk("model_busy", int'(BUSY), int'(m_busy));
    chk("model_ack", int'(DIV_ACK), int'(m_ack));
  endtask

  task automatic wait_level(input int lvl, input int limit, input string name);
    int n;
    n = 0;
    while (int'(CLKO) != lvl && n < limit) begin
      step();
      n++;
    end
    chk(name, int'(CLKO), lvl);
  endtask

  task automatic count_level(input int lvl, input int limit, output int n);
    n = 0;
    while (int'(CLKO) == lvl && n < limit) begin
      step();
      n++;
    end
  endtask

  task automatic wait_ack(input int limit, input string name);
    int n;
    n = 0;
    while (!DIV_ACK && n < limit) begin
      step();
      n++;
    end
    chk(name, int'(DIV_ACK), 1);
  endtask

  task automatic do_change(input int val, input int per);
    int hi;
    int lo;
    DIV_REQ = 1'b1;
    DIV_VAL = val[CNT_W-1:0];
    step();
    chk("busy_after_req", int'(BUSY), 1);
    DIV_VAL = CNT_W'($urandom);
    wait_ack(1200, "ack_seen");
    chk("clko_low_at_ack", int'(CLKO), 0);
    DIV_REQ = 1'b0;
    step();
    chk("ack_clear", int'(DIV_ACK), 0);
    chk("busy_clear", int'(BUSY), 0);
    wait_level(1, 1200, "rise_after_change");
    count_level(1, 1200, hi);
    count_level(0, 1200, lo);
    chk("high_phase", hi, per / 2);
    chk("low_phase", lo, per / 2);
    chk("period", hi + lo, per);
  endtask

  initial begin
    int n;
    vecs[0] = '{val: 3,   period: 8};
    vecs[1] = '{val: 0,   period: 2};
    vecs[2] = '{val: 5,   period: 12};
    vecs[3] = '{val: 1,   period: 4};
    vecs[4] = '{val: 255, period: 512};
    vecs[5] = '{val: 2,   period: 6};
    vecs[6] = '{val: 2,   period: 6};
    vecs[7] = '{val: 5,   period: 12};

    RN      = 1'b0;
    DIV_REQ = 1'b0;
    DIV_VAL = '0;
`ifdef GF180MCU_OSU_SC_CLKDIV_GATE_EN
    EN      = 1'b1;
`endif
    model_reset();
    repeat (3) @(posedge CLK);
    #1;
    chk("reset_clko", int'(CLKO), 0);
    chk("reset_busy", int'(BUSY), 0);
    chk("reset_ack", int'(DIV_ACK), 0);

    // Reset release with ratio 0: CLKO toggles every edge, first rise on edge 1.
    RN = 1'b1;
    step();
    chk("first_rise", int'(CLKO), 1);
    step();
    chk("first_fall", int'(CLKO), 0);
    step();
    chk("second_rise", int'(CLKO), 1);

    for (int i = 0; i < 8; i++) begin
      do_change(vecs[i].val, vecs[i].period);
    end

    // Ratio 5 -> 1 requested two cycles into a high phase.
    wait_level(1, 100, "t3_rise");
    step();
    step();
    DIV_REQ = 1'b1;
    DIV_VAL = 8'd1;
    count_level(1, 100, n);
    chk("t3_high_kept", n + 2, 6);
    chk("t3_ack_at_fall", int'(DIV_ACK), 1);
    count_level(0, 100, n);
    chk("t3_new_low", n, 2);
    DIV_REQ = 1'b0;
    step();
    chk("t3_ack_clear", int'(DIV_ACK), 0);

    // Request dropped while pending still completes; ack clears one cycle later.
    DIV_REQ = 1'b1;
    DIV_VAL = 8'd3;
    step();
    DIV_REQ = 1'b0;
    wait_ack(100, "drop_ack_seen");
    step();
    chk("drop_ack_clear", int'(DIV_ACK), 0);

    // Reset in the middle of a pending change, with the request left high.
    DIV_REQ = 1'b1;
    DIV_VAL = 8'd6;
    step();
    chk("pend_busy", int'(BUSY), 1);
    #2 RN = 1'b0;
    #1;
    chk("async_clko", int'(CLKO), 0);
    chk("async_busy", int'(BUSY), 0);
    chk("async_ack", int'(DIV_ACK), 0);
    model_reset();
    #2 RN = 1'b1;
    step();
    chk("rst_first_rise", int'(CLKO), 1);
    chk("rst_fresh_req", int'(BUSY), 1);
    step();
    chk("rst_ratio_fall", int'(CLKO), 0);
    chk("rst_fresh_ack", int'(DIV_ACK), 1);
    DIV_REQ = 1'b0;
    step();

    // Random request traffic with occasional asynchronous resets.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 9) == 0) DIV_REQ = ~DIV_REQ;
      if ($urandom_range(0, 3) == 0) DIV_VAL = CNT_W'($urandom_range(0, 7));
      if ($urandom_range(0, 599) == 0) begin
        #2 RN = 1'b0;
        #1;
        chk("rand_rst_clko", int'(CLKO), 0);
        model_reset();
        #1 RN = 1'b1;
      end
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
